writeback_queue: RTL
====================

Name: writeback_queue

Overview:
- Writeback stage directly upstream of the register file; sole driver of its write port (write_en, write_addr, write_data).
- Accepts results from two producers (ALU, load unit) via valid/ready and buffers them in an in-order FIFO.
- Drains one entry per cycle into the register file.
- Exposes a lookup port so decode can detect, and optionally forward, values still queued.

Parameters:
- WORDSIZE, 64, data width.
- ADDRW, 6, register address width.
- NUM_REGS, 32, number of architectural registers; legal addresses are 0..NUM_REGS-1.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU result present.
- alu_ready  output  1  ALU result accepted this cycle.
- alu_addr  input  ADDRW  destination register of the ALU result.
- alu_data  input  WORDSIZE  ALU result value.
- ld_valid  input  1  load result present.
- ld_ready  output  1  load result accepted this cycle.
- ld_addr  input  ADDRW  destination register of the load result.
- ld_data  input  WORDSIZE  load result value.
- write_en  output  1  write strobe to the register file.
- write_addr  output  ADDRW  register file write address.
- write_data  output  WORDSIZE  register file write data.
- fwd_addr  input  ADDRW  lookup address from decode.
- fwd_hit  output  1  fwd_addr is pending in the queue.
- fwd_data  output  WORDSIZE  value of the youngest queued entry for fwd_addr.
- count  output  log2(DEPTH)+1  number of occupied entries.
- err_addr  output  1  sticky flag: an out-of-range address was accepted.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high, named reset; it is sampled only on the rising edge of clk.
- Reset:
  - Pointers and count go to 0; all entries are invalidated; err_addr goes to 0.
  - Consequently write_en=0, fwd_hit=0, alu_ready=0, ld_ready=0 while reset is high.
  - Reset mid-operation discards all queued entries; none of them reach the register file.
- Handshake:
  - A transfer occurs on an edge where valid and ready are both high.
  - Each ready is combinational from registered count and alu_valid. It does not account for a same-cycle pop.
  - alu_ready = (count < DEPTH).
  - ld_ready = (count + (alu_valid & alu_ready) < DEPTH).
  - The ALU has priority. When both transfer in the same cycle, the ALU entry is enqueued as older, then the load entry.
- Filtering:
  - addr==0: handshake completes, nothing is enqueued (register 0 is hardwired).
  - addr >= NUM_REGS: handshake completes, nothing is enqueued, err_addr is set; it stays set until reset.
- Drain:
  - write_en = (count != 0). write_addr and write_data come combinationally from the head entry.
  - The head pops on every edge where write_en is high; the register file always accepts.
- Latency and ordering:
  - A result accepted at edge N is visible on the write port during cycle N+1 if the queue was otherwise empty, and is written at edge N+1.
  - Write order equals enqueue order. Two writes to the same register are applied oldest first.
- Count:
  - count' = count + pushes - pop, where pushes is 0..2 and pop is 0..1. count never exceeds DEPTH.
- Full: count==DEPTH gives alu_ready=0 and ld_ready=0, even though a pop occurs that cycle.
- One slot free with both producers valid: the ALU is accepted, ld_ready=0.
- Wrap-around: pointers are modulo DEPTH; count distinguishes full from empty.
- Lookup:
  - Purely combinational over valid queued entries only; results arriving in the same cycle are not included.
  - fwd_addr==0 always gives fwd_hit=0.

Optional Feature:
- Macro: WBQ_FWD_EN.
- Defined: fwd_data returns the youngest matching entry's data, using an age-priority search across the ring.
- Undefined: fwd_data is tied to 0. fwd_hit still reports presence, so decode stalls instead of forwarding.

Test Plan:
- Reset, then ALU push (addr 5, data 0xAA) at edge 1 -> write_en=1, write_addr=5, write_data=0xAA during cycle 2; count 1 then 0.
- ALU (addr 3, data 0x11) and load (addr 3, data 0x22) valid in the same cycle on an empty queue -> both accepted; writes 0x11 then 0x22 on consecutive cycles; fwd_addr=3 before draining gives fwd_hit=1 and fwd_data=0x22 (0 without WBQ_FWD_EN).
- Hold the queue full (DEPTH=4, pushes of two per cycle) -> alu_ready=0 and ld_ready=0 at count 4; at count 3 with both valid, ALU accepted and ld_ready=0; all entries drain in order with no loss across the pointer wrap.
- Push addr 0 (data 0xFF) and addr 40 -> both handshakes complete; count stays 0; write_en stays 0; err_addr=1 after the addr-40 edge and held until reset.
- Fill 3 entries, assert reset for one edge -> count=0, write_en=0, err_addr=0 next cycle; none of the 3 values is written.

Source files
------------

// File: rtl/writeback_queue.sv
// In-order writeback FIFO between the ALU/load producers and the register file write port.
// Optional macro WBQ_FWD_EN enables data forwarding on the lookup port; otherwise fwd_data is 0.
module writeback_queue #(
  parameter int WORDSIZE = 64,
  parameter int ADDRW    = 6,
  parameter int NUM_REGS = 32,
  parameter int DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [ADDRW-1:0]        alu_addr,
  input  logic [WORDSIZE-1:0]     alu_data,

  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [ADDRW-1:0]        ld_addr,
  input  logic [WORDSIZE-1:0]     ld_data,

  output logic                    write_en,
  output logic [ADDRW-1:0]        write_addr,
  output logic [WORDSIZE-1:0]     write_data,

  input  logic [ADDRW-1:0]        fwd_addr,
  output logic                    fwd_hit,
  output logic [WORDSIZE-1:0]     fwd_data,

  output logic [$clog2(DEPTH):0]  count,
  output logic                    err_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [ADDRW:0]   NREGS_C = (ADDRW + 1)'(NUM_REGS);

  logic [ADDRW-1:0]    addr_q [DEPTH];
  logic [WORDSIZE-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]    valid_q;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] ld_slot;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] ld_room;
  logic          err_q, err_d;

  logic alu_fire, ld_fire;
  logic alu_push, ld_push;
  logic pop;

  logic                match;
  logic [WORDSIZE-1:0] match_data;
  logic [PW-1:0]       scan_idx;

  function automatic logic addrLegal(input logic [ADDRW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS_C);
  endfunction

  function automatic logic addrBad(input logic [ADDRW-1:0] a);
    return {1'b0, a} >= NREGS_C;
  endfunction

  // Ready ignores a same-cycle pop; the load only sees room left after an ALU accept.
  assign alu_ready = ~reset & (count_q < DEPTH_C);
  assign ld_room   = count_q + CW'(alu_valid & alu_ready);
  assign ld_ready  = ~reset & (ld_room < DEPTH_C);

  assign alu_fire = alu_valid & alu_ready;
  assign ld_fire  = ld_valid  & ld_ready;

  // Register 0 and out-of-range destinations complete the handshake but are dropped.
  assign alu_push = alu_fire & addrLegal(alu_addr);
  assign ld_push  = ld_fire  & addrLegal(ld_addr);

  assign write_en   = ~reset & (count_q != '0);
  assign write_addr = addr_q[head_q];
  assign write_data = data_q[head_q];
  assign pop        = write_en;

  assign ld_slot = tail_q + PW'(alu_push);

  always_comb begin
    count_d = count_q + CW'(alu_push) + CW'(ld_push) - CW'(pop);
    tail_d  = tail_q + PW'(alu_push) + PW'(ld_push);
    head_d  = head_q + PW'(pop);
    err_d   = err_q | (alu_fire & addrBad(alu_addr)) | (ld_fire & addrBad(ld_addr));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (pop) begin
        valid_q[head_q] <= 1'b0;
      end
      if (alu_push) begin
        valid_q[tail_q] <= 1'b1;
      end
      if (ld_push) begin
        valid_q[ld_slot] <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset; valid_q qualifies every read of it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (alu_push) begin
        addr_q[tail_q] <= alu_addr;
        data_q[tail_q] <= alu_data;
      end
      if (ld_push) begin
        addr_q[ld_slot] <= ld_addr;
        data_q[ld_slot] <= ld_data;
      end
    end
  end

  // Walk oldest to youngest from the head so the last match is the youngest entry.
  always_comb begin
    match      = 1'b0;
    match_data = '0;
    scan_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (valid_q[scan_idx] && (addr_q[scan_idx] == fwd_addr)) begin
        match      = 1'b1;
        match_data = data_q[scan_idx];
      end
    end
  end

  assign fwd_hit = ~reset & (fwd_addr != '0) & match;

`ifdef WBQ_FWD_EN
  assign fwd_data = fwd_hit ? match_data : '0;
`else
  assign fwd_data = '0;
`endif

  assign count    = count_q;
  assign err_addr = err_q;

endmodule
